// File: rtl/vga_if.sv
// VGA timing bundle shared by the menu pipeline stages.
// Renderers take it through "in" and drive it through "out".
interface vga_if;
  logic [11:0] hcount;
  logic [11:0] vcount;
  logic        hblnk;
  logic        vblnk;
  logic        hsync;
  logic        vsync;

  modport in     (input  hcount, vcount, hblnk, vblnk, hsync, vsync);
  modport out    (output hcount, vcount, hblnk, vblnk, hsync, vsync);
  modport slave  (input  hcount, vcount, hblnk, vblnk, hsync, vsync);
  modport master (output hcount, vcount, hblnk, vblnk, hsync, vsync);
endinterface

// File: rtl/menu_buttons.sv
// Menu button renderer and click decoder: draws stacked bordered buttons over the
// incoming VGA stream and turns a press+release on one button into a selection pulse.
module menu_buttons #(
  parameter int N_BUTTONS = 3,
  parameter int X0 = 412,
  parameter int Y0 = 200,
  parameter int W = 200,
  parameter int H = 60,
  parameter int GAP = 40,
  parameter int BORDER_W = 2,
  parameter int RGB_B = 12,
  parameter logic [RGB_B-1:0] RECT_COLOR = 12'h0F0,
  parameter logic [RGB_B-1:0] HOVER_COLOR = 12'h0C0,
  parameter logic [RGB_B-1:0] PRESS_COLOR = 12'h080,
  parameter logic [RGB_B-1:0] BORDER_COLOR = 12'h000,
  localparam int IDX_W = (N_BUTTONS > 1) ? $clog2(N_BUTTONS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [11:0]      mouse_x,
  input  logic [11:0]      mouse_y,
  input  logic             mouse_left,
  vga_if.in                vga_in,
  input  logic [RGB_B-1:0] rgb_i,
  vga_if.out               vga_out,
  output logic [RGB_B-1:0] rgb_o,
  output logic             hover_valid,
  output logic [IDX_W-1:0] hover_idx,
  output logic             sel_valid,
  output logic [IDX_W-1:0] sel_idx
);

  localparam logic [11:0] X_LO = 12'(X0);
  localparam logic [11:0] X_HI = 12'(X0 + W - 1);
  localparam logic [11:0] BW   = 12'(BORDER_W);

  typedef enum logic [1:0] {IDLE, PRESS, IGNORE} state_t;

  function automatic logic [11:0] y_lo(input int k);
    return 12'(Y0 + k * (H + GAP));
  endfunction

  function automatic logic [11:0] y_hi(input int k);
    return 12'(Y0 + k * (H + GAP) + H - 1);
  endfunction

  function automatic logic in_box(input logic [11:0] x, input logic [11:0] y, input int k);
    return (x >= X_LO) && (x <= X_HI) && (y >= y_lo(k)) && (y <= y_hi(k));
  endfunction

  // Only meaningful when the point is inside the box, so the subtractions never wrap.
  function automatic logic near_edge(input logic [11:0] x, input logic [11:0] y, input int k);
    return ((x - X_LO) < BW) || ((X_HI - x) < BW) ||
           ((y - y_lo(k)) < BW) || ((y_hi(k) - y) < BW);
  endfunction

  logic [N_BUTTONS-1:0] inside_c, border_c, s1_inside, s1_border;
  logic [11:0]          s1_hcount, s1_vcount;
  logic                 s1_hblnk, s1_vblnk, s1_hsync, s1_vsync;
  logic [RGB_B-1:0]     s1_rgb, pix_c;
  logic [11:0]          mx_q, my_q;
  logic                 hit_any;
  logic [IDX_W-1:0]     hit_idx, press_idx;
  logic                 btn_q, btn_d, btn_dd, rise, sel_fire;
  state_t               state, state_nxt;

  always_comb begin
    for (int k = 0; k < N_BUTTONS; k++) begin
      inside_c[k] = in_box(vga_in.hcount, vga_in.vcount, k);
      border_c[k] = inside_c[k] && near_edge(vga_in.hcount, vga_in.vcount, k);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_hcount <= '0;
      s1_vcount <= '0;
      s1_hblnk  <= 1'b0;
      s1_vblnk  <= 1'b0;
      s1_hsync  <= 1'b0;
      s1_vsync  <= 1'b0;
      s1_rgb    <= '0;
      s1_inside <= '0;
      s1_border <= '0;
    end else begin
      s1_hcount <= vga_in.hcount;
      s1_vcount <= vga_in.vcount;
      s1_hblnk  <= vga_in.hblnk;
      s1_vblnk  <= vga_in.vblnk;
      s1_hsync  <= vga_in.hsync;
      s1_vsync  <= vga_in.vsync;
      s1_rgb    <= rgb_i;
      s1_inside <= inside_c;
      s1_border <= border_c;
    end
  end

  // Walk from the top index down so the lowest overlapping button ends up on top.
  always_comb begin
    pix_c = s1_rgb;
    for (int k = N_BUTTONS - 1; k >= 0; k--) begin
      if (s1_inside[k]) begin
        if (s1_border[k])
          pix_c = BORDER_COLOR;
        else if (state == PRESS && press_idx == IDX_W'(k) && hover_valid && hover_idx == IDX_W'(k))
          pix_c = PRESS_COLOR;
        else if (hover_valid && hover_idx == IDX_W'(k) && enable)
          pix_c = HOVER_COLOR;
        else
          pix_c = RECT_COLOR;
      end
    end
    if (s1_hblnk || s1_vblnk)
      pix_c = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vga_out.hcount <= '0;
      vga_out.vcount <= '0;
      vga_out.hblnk  <= 1'b0;
      vga_out.vblnk  <= 1'b0;
      vga_out.hsync  <= 1'b0;
      vga_out.vsync  <= 1'b0;
      rgb_o          <= '0;
    end else begin
      vga_out.hcount <= s1_hcount;
      vga_out.vcount <= s1_vcount;
      vga_out.hblnk  <= s1_hblnk;
      vga_out.vblnk  <= s1_vblnk;
      vga_out.hsync  <= s1_hsync;
      vga_out.vsync  <= s1_vsync;
      rgb_o          <= pix_c;
    end
  end

  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int k = N_BUTTONS - 1; k >= 0; k--) begin
      if (in_box(mx_q, my_q, k)) begin
        hit_any = 1'b1;
        hit_idx = IDX_W'(k);
      end
    end
  end

  // Button history resets high so a button held through reset never looks like a new press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mx_q        <= '0;
      my_q        <= '0;
      hover_valid <= 1'b0;
      hover_idx   <= '0;
      btn_q       <= 1'b1;
      btn_d       <= 1'b1;
      btn_dd      <= 1'b1;
    end else begin
      mx_q        <= mouse_x;
      my_q        <= mouse_y;
      hover_valid <= hit_any && enable;
      hover_idx   <= hit_idx;
      btn_q       <= mouse_left;
      btn_d       <= btn_q;
      btn_dd      <= btn_d;
    end
  end

  assign rise = btn_d && !btn_dd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      press_idx <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && rise && hover_valid && enable)
        press_idx <= hover_idx;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rise) state_nxt = hover_valid ? PRESS : IGNORE;
      PRESS:   if (!btn_d) state_nxt = IDLE;
      IGNORE:  if (!btn_d) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (!enable)
      state_nxt = IDLE;
  end

  always_comb begin
    sel_fire = enable && state == PRESS && !btn_d && hover_valid && hover_idx == press_idx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_valid <= 1'b0;
      sel_idx   <= '0;
    end else begin
      sel_valid <= sel_fire;
      if (sel_fire)
        sel_idx <= press_idx;
    end
  end

endmodule

// File: tb/tb_menu_buttons.sv
// Directed bench for menu_buttons: pixel vector table plus hand-written click sequences.
module tb_menu_buttons;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [11:0] mouse_x, mouse_y;
  logic        mouse_left;
  logic [11:0] rgb_i;
  logic [11:0] rgb_o;
  logic        hover_valid;
  logic [1:0]  hover_idx;
  logic        sel_valid;
  logic [1:0]  sel_idx;
  int          checks = 0;
  int          errors = 0;

  vga_if vin();
  vga_if vout();

  always #5 clk = ~clk;

  menu_buttons dut (
    .clk(clk), .rst(rst_n), .enable(enable),
    .mouse_x(mouse_x), .mouse_y(mouse_y), .mouse_left(mouse_left),
    .vga_in(vin), .rgb_i(rgb_i), .vga_out(vout), .rgb_o(rgb_o),
    .hover_valid(hover_valid), .hover_idx(hover_idx),
    .sel_valid(sel_valid), .sel_idx(sel_idx)
  );

  typedef struct {
    logic [11:0] h;
    logic [11:0] v;
    logic        hb;
    logic        vb;
    logic [11:0] bg;
    logic [11:0] exp;
    string       name;
  } pix_vec_t;

  pix_vec_t vecs[18];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Drive one pixel, hold it through both pipeline stages, then compare all outputs.
  task automatic apply_stimulus(input pix_vec_t pv);
    vin.hcount = pv.h;
    vin.vcount = pv.v;
    vin.hblnk  = pv.hb;
    vin.vblnk  = pv.vb;
    vin.hsync  = pv.h[0];
    vin.vsync  = pv.v[0];
    rgb_i      = pv.bg;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check_output({pv.name, " rgb"}, 32'(rgb_o), 32'(pv.exp));
    check_output({pv.name, " hcount"}, 32'(vout.hcount), 32'(pv.h));
    check_output({pv.name, " vcount"}, 32'(vout.vcount), 32'(pv.v));
    check_output({pv.name, " blank"}, {30'd0, vout.hblnk, vout.vblnk}, {30'd0, pv.hb, pv.vb});
  endtask

  task automatic count_pulses(input int cycles, input int exp, input string name);
    int n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (sel_valid) n++;
    end
    check_output(name, 32'(n), 32'(exp));
  endtask

  // Full click with the pulse position checked cycle by cycle after the release edge.
  task automatic click_check(input logic [11:0] x, input logic [11:0] y,
                             input logic [1:0] exp_idx, input string name);
    mouse_x = x;
    mouse_y = y;
    repeat (4) @(negedge clk);
    check_output({name, " hover_idx"}, 32'(hover_idx), 32'(exp_idx));
    mouse_left = 1'b1;
    repeat (5) @(negedge clk);
    mouse_left = 1'b0;
    @(negedge clk);
    check_output({name, " sel n+0"}, 32'(sel_valid), 32'd0);
    @(negedge clk);
    check_output({name, " sel n+1"}, 32'(sel_valid), 32'd0);
    @(negedge clk);
    check_output({name, " sel n+2"}, 32'(sel_valid), 32'd1);
    check_output({name, " sel_idx"}, 32'(sel_idx), 32'(exp_idx));
    @(negedge clk);
    check_output({name, " sel n+3"}, 32'(sel_valid), 32'd0);
  endtask

  task automatic press_and_hold(input logic [11:0] x, input logic [11:0] y);
    mouse_x = x;
    mouse_y = y;
    repeat (4) @(negedge clk);
    mouse_left = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    logic [11:0] hist[20];

    vecs[0]  = '{12'd500, 12'd230, 1'b0, 1'b0, 12'hABC, 12'h0F0, "b0 interior"};
    vecs[1]  = '{12'd500, 12'd330, 1'b0, 1'b0, 12'hABC, 12'h0F0, "b1 interior"};
    vecs[2]  = '{12'd500, 12'd430, 1'b0, 1'b0, 12'hABC, 12'h0C0, "b2 hover interior"};
    vecs[3]  = '{12'd412, 12'd430, 1'b0, 1'b0, 12'hABC, 12'h000, "b2 left edge"};
    vecs[4]  = '{12'd413, 12'd430, 1'b0, 1'b0, 12'hABC, 12'h000, "b2 left border 2"};
    vecs[5]  = '{12'd414, 12'd430, 1'b0, 1'b0, 12'hABC, 12'h0C0, "b2 past left border"};
    vecs[6]  = '{12'd611, 12'd430, 1'b0, 1'b0, 12'hABC, 12'h000, "b2 right edge"};
    vecs[7]  = '{12'd609, 12'd430, 1'b0, 1'b0, 12'hABC, 12'h0C0, "b2 past right border"};
    vecs[8]  = '{12'd500, 12'd400, 1'b0, 1'b0, 12'hABC, 12'h000, "b2 top edge"};
    vecs[9]  = '{12'd500, 12'd459, 1'b0, 1'b0, 12'hABC, 12'h000, "b2 bottom edge"};
    vecs[10] = '{12'd500, 12'd457, 1'b0, 1'b0, 12'hABC, 12'h0C0, "b2 past bottom border"};
    vecs[11] = '{12'd500, 12'd460, 1'b0, 1'b0, 12'hABC, 12'hABC, "below b2"};
    vecs[12] = '{12'd411, 12'd430, 1'b0, 1'b0, 12'h123, 12'h123, "left of b2"};
    vecs[13] = '{12'd612, 12'd230, 1'b0, 1'b0, 12'h456, 12'h456, "right of b0"};
    vecs[14] = '{12'd500, 12'd280, 1'b0, 1'b0, 12'h789, 12'h789, "gap b0 b1"};
    vecs[15] = '{12'd500, 12'd430, 1'b1, 1'b0, 12'hABC, 12'h000, "hblank"};
    vecs[16] = '{12'd500, 12'd430, 1'b0, 1'b1, 12'hABC, 12'h000, "vblank"};
    vecs[17] = '{12'd0,   12'd0,   1'b0, 1'b0, 12'hFFF, 12'hFFF, "origin bg"};

    // Reset with the mouse button held and live timing on the input.
    rst_n = 1'b0;
    enable = 1'b1;
    mouse_x = 12'd500;
    mouse_y = 12'd330;
    mouse_left = 1'b1;
    rgb_i = 12'hABC;
    vin.hcount = 12'd500;
    vin.vcount = 12'd330;
    vin.hblnk = 1'b1;
    vin.vblnk = 1'b1;
    vin.hsync = 1'b1;
    vin.vsync = 1'b1;
    repeat (3) @(negedge clk);
    check_output("reset rgb_o", 32'(rgb_o), 32'd0);
    check_output("reset vga_out", {vout.hcount, vout.vcount, vout.hblnk, vout.vblnk, vout.hsync, vout.vsync}, 32'd0);
    check_output("reset hover", {29'd0, hover_valid, hover_idx}, 32'd0);
    check_output("reset sel", {29'd0, sel_valid, sel_idx}, 32'd0);

    rst_n = 1'b1;
    count_pulses(100, 0, "held through reset");
    check_output("held hover_valid", 32'(hover_valid), 32'd1);
    check_output("held hover_idx", 32'(hover_idx), 32'd1);
    mouse_left = 1'b0;
    count_pulses(10, 0, "release after reset hold");

    click_check(12'd412, 12'd300, 2'd1, "click b1 corner");

    press_and_hold(12'd500, 12'd230);
    mouse_y = 12'd430;
    repeat (5) @(negedge clk);
    mouse_left = 1'b0;
    count_pulses(10, 0, "drag b0 to b2");
    check_output("drag keeps sel_idx", 32'(sel_idx), 32'd1);

    press_and_hold(12'd100, 12'd100);
    mouse_x = 12'd500;
    mouse_y = 12'd330;
    repeat (5) @(negedge clk);
    mouse_left = 1'b0;
    count_pulses(10, 0, "drag empty to b1");

    click_check(12'd611, 12'd459, 2'd2, "click b2 corner");

    // Slide off and back while held keeps the press; press colour shows on the held button.
    press_and_hold(12'd500, 12'd330);
    mouse_x = 12'd100;
    repeat (4) @(negedge clk);
    mouse_x = 12'd500;
    repeat (4) @(negedge clk);
    apply_stimulus('{12'd500, 12'd330, 1'b0, 1'b0, 12'hABC, 12'h080, "b1 pressed"});
    apply_stimulus('{12'd500, 12'd430, 1'b0, 1'b0, 12'hABC, 12'h0F0, "b2 idle during press"});
    mouse_left = 1'b0;
    count_pulses(10, 1, "slide off and back");
    check_output("slide sel_idx", 32'(sel_idx), 32'd1);

    press_and_hold(12'd500, 12'd330);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check_output("disabled hover_valid", 32'(hover_valid), 32'd0);
    apply_stimulus('{12'd500, 12'd330, 1'b0, 1'b0, 12'hABC, 12'h0F0, "b1 disabled idle"});
    mouse_left = 1'b0;
    count_pulses(10, 0, "release while disabled");
    enable = 1'b1;
    click_check(12'd412, 12'd200, 2'd0, "reenabled click b0");

    press_and_hold(12'd500, 12'd330);
    rst_n = 1'b0;
    #1;
    check_output("midpress reset sel", {29'd0, sel_valid, sel_idx}, 32'd0);
    check_output("midpress reset hover", 32'(hover_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    count_pulses(20, 0, "held after midpress reset");
    mouse_left = 1'b0;
    count_pulses(10, 0, "release after midpress reset");
    click_check(12'd500, 12'd359, 2'd1, "click b1 after reset");

    // Pixel table with the mouse resting on button 2.
    mouse_x = 12'd500;
    mouse_y = 12'd430;
    repeat (4) @(negedge clk);
    check_output("table hover_idx", 32'(hover_idx), 32'd2);
    for (int i = 0; i < 18; i++)
      apply_stimulus(vecs[i]);

    // Streaming timing: vga_out must be vga_in from two cycles earlier.
    for (int i = 0; i < 20; i++) begin
      if (i >= 2)
        check_output($sformatf("stream %0d hcount", i), 32'(vout.hcount), 32'(hist[i-2]));
      hist[i] = 12'(i * 37 + 5);
      vin.hcount = hist[i];
      vin.vcount = 12'(i);
      vin.hsync = hist[i][0];
      vin.vsync = 1'b0;
      vin.hblnk = 1'b0;
      vin.vblnk = 1'b0;
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
